eth_fcs_sequencer: RTL and testbench

ETH_FCS_SEQUENCER -- requirements
Module: eth_fcs_sequencer

---
 rtl/eth_fcs_sequencer.sv | 176 +++++++++++++++++
 tb/tb_eth_fcs_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_sequencer.sv
// eth_fcs_sequencer: passes payload bytes through a one-entry output register,
// feeds each byte LSB-first to an external serial CRC-32 engine, then appends
// the four FCS bytes taken from that engine.
// Optional zero padding up to MIN_FRAME pre-FCS bytes: define ETH_FCS_PAD_EN.
module eth_fcs_sequencer #(
  parameter int unsigned MIN_FRAME = 60
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_clear,
  output logic        crc_en,
  output logic        crc_bit,
  input  logic [31:0] crc_value,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CLR, DATA, SHIFT, PAD, LATCH, FCS} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [15:0] byte_cnt;
  logic        last_seen;
  logic [31:0] fcs;
  logic [1:0]  fcs_idx;
  logic        fcs_done;
  logic        pad_req;
  logic        load_byte;
  logic [7:0]  load_val;
  logic        fcs_load;
  logic [7:0]  fcs_byte;

`ifdef ETH_FCS_PAD_EN
  assign pad_req = (byte_cnt < 16'(MIN_FRAME));
`else
  logic unused_pad;
  assign pad_req    = 1'b0;
  assign unused_pad = ^{byte_cnt, 16'(MIN_FRAME)};
`endif

  assign busy = (state != IDLE);

  // Select the FCS byte to emit next, least significant byte first.
  always_comb begin
    fcs_byte = fcs[7:0];
    case (fcs_idx)
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  // Next-state decode plus the CRC-engine and handshake strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    load_byte = 1'b0;
    load_val  = in_data;
    fcs_load  = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = CLR;
      CLR: begin
        crc_clear = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        in_ready = !out_valid;
        if (in_valid && !out_valid) begin
          load_byte = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        crc_en  = 1'b1;
        crc_bit = shreg[0];
        if (bit_cnt == 3'd7) begin
          if (!last_seen)   state_nxt = DATA;
          else if (pad_req) state_nxt = PAD;
          else              state_nxt = LATCH;
        end
      end
`ifdef ETH_FCS_PAD_EN
      PAD: begin
        if (!out_valid) begin
          load_byte = 1'b1;
          load_val  = 8'h00;
          state_nxt = SHIFT;
        end
      end
`endif
      LATCH: state_nxt = FCS;
      FCS: begin
        if (fcs_done && out_valid && out_ready) state_nxt = IDLE;
        else if (!fcs_done && (!out_valid || out_ready)) fcs_load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Shift register, byte counter, end-of-payload flag and FCS holding register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      last_seen <= 1'b0;
      fcs       <= '0;
      fcs_idx   <= '0;
      fcs_done  <= 1'b0;
    end else begin
      if (state == CLR) begin
        byte_cnt  <= '0;
        last_seen <= 1'b0;
      end
      if (load_byte) begin
        shreg   <= load_val;
        bit_cnt <= '0;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
        // Pad bytes keep the flag set so SHIFT keeps routing back to PAD.
        if (state == DATA) last_seen <= in_last;
      end else if (state == SHIFT) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == LATCH) begin
        fcs      <= crc_value;
        fcs_idx  <= '0;
        fcs_done <= 1'b0;
      end else if (fcs_load) begin
        fcs_idx <= fcs_idx + 2'd1;
        if (fcs_idx == 2'd3) fcs_done <= 1'b1;
      end
    end
  end

  // One-entry output holding register; contents frozen while stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load_byte) begin
      out_valid <= 1'b1;
      out_data  <= load_val;
      out_last  <= 1'b0;
    end else if (fcs_load) begin
      out_valid <= 1'b1;
      out_data  <= fcs_byte;
      out_last  <= (fcs_idx == 2'd3);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_fcs_sequencer.sv
// tb_eth_fcs_sequencer: drives eth_fcs_sequencer with directed and random
// frames, models the serial CRC-32 engine, and scores the output stream
// against a byte-level frame/CRC model. Honours ETH_FCS_PAD_EN.
module tb_eth_fcs_sequencer;

  localparam int unsigned MIN_FRAME = 60;

  typedef logic [7:0] bq_t [$];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        crc_clear;
  logic        crc_en;
  logic        crc_bit;
  logic [31:0] crc_value;
  logic        busy;

  eth_fcs_sequencer #(.MIN_FRAME(MIN_FRAME)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .crc_clear (crc_clear),
    .crc_en    (crc_en),
    .crc_bit   (crc_bit),
    .crc_value (crc_value),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Serial reflected CRC-32 engine fed by the DUT.
  logic [31:0] eng = '1;
  always @(posedge clock) begin
    if (crc_clear === 1'b1) eng <= '1;
    else if (crc_en === 1'b1)
      eng <= (eng >> 1) ^ (((eng[0] ^ crc_bit) === 1'b1) ? 32'hEDB88320 : 32'h0);
  end
  assign crc_value = ~eng;

  // Observation counters and captured output stream.
  int unsigned n_en = 0, n_clr = 0, n_rx = 0, n_lastrx = 0, n_fall = 0, n_viol = 0;
  logic [7:0] rx_byte [0:16383];
  logic       rx_last [0:16383];
  logic       p_rst = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_busy = 1'b0;
  logic [7:0] p_data = '0;

  // Sample on the falling edge: count strobes, log transfers, check invariants.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (crc_en === 1'b1) n_en++;
      if (crc_clear === 1'b1) n_clr++;
      if (crc_en !== 1'b1 && crc_bit !== 1'b0) n_viol++;
      if (crc_en === 1'b1 && crc_clear === 1'b1) n_viol++;
      if (in_ready === 1'b1 && out_valid === 1'b1) n_viol++;
      if (p_rst && p_valid && !p_ready &&
          (out_valid !== 1'b1 || out_data !== p_data || out_last !== p_last)) n_viol++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (n_rx < 16384) begin
          rx_byte[n_rx] = out_data;
          rx_last[n_rx] = out_last;
        end
        n_rx++;
        if (out_last === 1'b1) n_lastrx++;
      end
      if (p_busy && busy === 1'b0) n_fall++;
    end
    p_rst   = (reset_n === 1'b1);
    p_valid = (out_valid === 1'b1);
    p_ready = (out_ready === 1'b1);
    p_data  = out_data;
    p_last  = (out_last === 1'b1);
    p_busy  = (busy === 1'b1);
  end

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-32 of a byte sequence (reflected, init all-ones, final invert).
  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c;
    c = '1;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected stream for the frames of the current run.
  bq_t        exp_q;
  logic       lst_q [$];
  logic [8:0] drv_q [$];
  int unsigned en_exp;
  int unsigned last_rx0;

  function automatic void add_frame(input bq_t p);
    bq_t body;
    logic [31:0] c;
    body = p;
`ifdef ETH_FCS_PAD_EN
    while (body.size() < MIN_FRAME) body.push_back(8'h00);
`endif
    foreach (p[i]) drv_q.push_back({(i == p.size() - 1), p[i]});
    c = crc32(body);
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      lst_q.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(c[8*k +: 8]);
      lst_q.push_back(k == 3);
    end
    en_exp += 8 * body.size();
  endfunction

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic l, output bit ok);
    int unsigned w;
    w = 0;
    ok = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (in_ready !== 1'b1) begin
      w++;
      if (w > 3000) begin
        ok = 1'b0;
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_all(output bit ok);
    bit okb;
    ok = 1'b1;
    foreach (drv_q[i]) begin
      drive_byte(drv_q[i][7:0], drv_q[i][8], okb);
      if (!okb) begin
        ok = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sink(input int unsigned nlast, input int stall_at, input logic [7:0] sbyte,
                      output bit ok);
    int unsigned cyc, l0, r0, w, nbad;
    bit stalled;
    logic [7:0] d0;
    ok = 1'b1;
    cyc = 0;
    l0 = n_lastrx;
    r0 = n_rx;
    stalled = 1'b0;
    while (n_lastrx - l0 < nlast) begin
      if (stall_at >= 0 && !stalled && (n_rx - r0) == unsigned'(stall_at)) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        w = 0;
        while (out_valid !== 1'b1 && w < 200) begin
          w++;
          @(negedge clock);
        end
        d0 = out_data;
        nbad = 0;
        repeat (20) begin
          if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) nbad++;
          @(negedge clock);
        end
        check("stall_hold", nbad, 0);
        check("stall_byte", {24'h0, d0}, {24'h0, sbyte});
        @(posedge clock);
        #1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clock);
        #1;
      end
      cyc++;
      if (cyc > 30000) begin
        ok = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic run_frames(input bq_t f1, input bq_t f2, input int unsigned nf,
                            input int stall_at, input string tag);
    int unsigned en0, clr0, rx0, fall0, viol0, got;
    bit ok_d, ok_s;
    logic [7:0] sbyte;
    exp_q.delete();
    lst_q.delete();
    drv_q.delete();
    en_exp = 0;
    add_frame(f1);
    if (nf == 2) add_frame(f2);
    align();
    en0 = n_en; clr0 = n_clr; rx0 = n_rx; fall0 = n_fall; viol0 = n_viol;
    last_rx0 = rx0;
    sbyte = (stall_at >= 0) ? exp_q[stall_at] : 8'h00;
    fork
      drive_all(ok_d);
      sink(nf, stall_at, sbyte, ok_s);
    join
    repeat (2) @(negedge clock);
    check({tag, " input_done"}, 32'(ok_d), 32'd1);
    check({tag, " output_done"}, 32'(ok_s), 32'd1);
    got = n_rx - rx0;
    check({tag, " byte_count"}, got, exp_q.size());
    for (int i = 0; i < int'(exp_q.size()) && i < int'(got); i++) begin
      check($sformatf("%s byte%0d", tag, i), {24'h0, rx_byte[rx0 + i]}, {24'h0, exp_q[i]});
      check($sformatf("%s last%0d", tag, i), 32'(rx_last[rx0 + i]), 32'(lst_q[i]));
    end
    check({tag, " crc_en_cycles"}, n_en - en0, en_exp);
    check({tag, " crc_clear_pulses"}, n_clr - clr0, nf);
    check({tag, " busy_falls"}, n_fall - fall0, nf);
    check({tag, " protocol"}, n_viol - viol0, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_data"}, {24'h0, out_data}, 32'd0);
    check({tag, " out_last"}, 32'(out_last), 32'd0);
    check({tag, " crc_clear"}, 32'(crc_clear), 32'd0);
    check({tag, " crc_en"}, 32'(crc_en), 32'd0);
    check({tag, " crc_bit"}, 32'(crc_bit), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f1, f2, none;
    logic [7:0] lit [0:12];
    bit ok;
    none = {};

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_quiet("reset");

    // Known check vector "123456789".
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frames(f1, none, 1, -1, "check_vec");
`ifndef ETH_FCS_PAD_EN
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 13; i++)
      check($sformatf("check_vec literal%0d", i), {24'h0, rx_byte[last_rx0 + i]}, {24'h0, lit[i]});
`endif

    // Single-byte frame (padded to MIN_FRAME when padding is built in).
    f1 = '{8'hAA};
    run_frames(f1, none, 1, -1, "one_byte");

    // Exactly MIN_FRAME bytes: never padded.
    f1 = {};
    for (int i = 0; i < int'(MIN_FRAME); i++) f1.push_back(8'($urandom));
    run_frames(f1, none, 1, -1, "min_frame");

    // Output stalled for 20 cycles while byte 3 is held.
    f1 = {};
    for (int i = 0; i < 12; i++) f1.push_back(8'($urandom));
    run_frames(f1, none, 1, 3, "stall");

    // Reset during the SHIFT of the fifth payload byte.
    align();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_byte(8'($urandom), 1'b0, ok);
      check($sformatf("abort accept%0d", i), 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("abort in_shift", 32'(crc_en), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_quiet("mid_shift_reset");
    out_ready = 1'b0;
    f1 = {};
    for (int i = 0; i < 8; i++) f1.push_back(8'($urandom));
    run_frames(f1, none, 1, -1, "after_reset");

    // Two frames back to back with in_valid held high.
    f1 = {};
    f2 = {};
    for (int i = 0; i < 6; i++) f1.push_back(8'($urandom));
    for (int i = 0; i < 10; i++) f2.push_back(8'($urandom));
    run_frames(f1, f2, 2, -1, "back_to_back");

    // Random lengths and contents with random output backpressure.
    for (int n = 0; n < 5; n++) begin
      f1 = {};
      for (int i = 0; i < int'($urandom_range(1, 70)); i++) f1.push_back(8'($urandom));
      run_frames(f1, none, 1, -1, $sformatf("random%0d", n));
    end

    check("protocol_total", n_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
